// File: rtl/bch_ecc_serializer_pkg.sv
// Shared types and derivation helpers for the BCH ECC serializer.
// Code-parameter set, FSM encoding and the width formulas that every
// file uses, so that no derived width is restated as a bare number.
package bch_ecc_serializer_pkg;

    // BCH code parameter set: Galois-field order m and correction power t.
    typedef struct packed {
        logic [7:0] m;
        logic [7:0] t;
    } bch_params_t;

    // Default code: m=13, t=8, giving a 104-bit ECC remainder.
    localparam bch_params_t BCH_SANE = '{m: 8'd13, t: 8'd8};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Number of ECC remainder bits for a code parameter set.
    function automatic int bch_ecc_bits(bch_params_t p);
        return int'(p.m) * int'(p.t);
    endfunction

    // Number of output words needed to carry eb bits, bits at a time.
    function automatic int bch_ecc_words(int eb, int bits);
        return (eb + bits - 1) / bits;
    endfunction

    // Word-index register width able to hold 0..words.
    function automatic int bch_index_width(int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/bch_ecc_serializer_if.sv
// Valid/ready output stream carrying ECC words with first/last markers.
interface bch_ecc_serializer_if #(
    parameter int BITS = 1
) ();

    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_first;
    logic            out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/bch_ecc_serializer_counter.sv
// Saturating up-counter with synchronous clear, used as the word index.
// Clear wins over increment; the count stops at MAX and never wraps.
module bch_ecc_serializer_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1'b1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_V)) begin
            count_d = count_q + ONE_V;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bch_ecc_serializer.sv
// BCH ECC serializer: loads a parallel ECC remainder, left-aligns it and
// emits it MSB-first as BITS-wide words on a valid/ready stream, optionally
// XORed with the blank-flash mask supplied by an upstream generator.
module bch_ecc_serializer
    import bch_ecc_serializer_pkg::*;
#(
    parameter bch_params_t P    = BCH_SANE,
    parameter int          BITS = 1,
    localparam int         EB   = bch_ecc_bits(P)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [EB-1:0]                ecc_in,
    input  logic                         ecc_load,
    output logic                         ecc_ready,
    input  logic                         blank_en,
    input  logic                         flush,
    output logic                         blank_start,
    output logic                         blank_ce,
    input  logic [BITS-1:0]              blank_xor,
    bch_ecc_serializer_if.master         out_if
);

    localparam int ECC_WORDS = bch_ecc_words(EB, BITS);
    localparam int SW        = ECC_WORDS * BITS;
    localparam int PAD       = SW - EB;
    localparam int IW        = bch_index_width(ECC_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ECC_WORDS - 1);

    state_e          state_q;
    state_e          state_d;
    logic [SW-1:0]   shreg_q;
    logic [SW-1:0]   shreg_d;
    logic            blank_en_q;
    logic            blank_en_d;

    logic [IW-1:0]   idx_s;
    logic            idx_clr_s;
    logic            idx_inc_s;
    logic            is_send_s;
    logic            is_last_s;
    logic            hs_s;
    logic            load_acc_s;
    logic [BITS-1:0] mask_s;

    // Word index; saturates at the last word so it can never wrap.
    bch_ecc_serializer_counter #(
        .MAX (ECC_WORDS - 1),
        .W   (IW)
    ) u_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (idx_clr_s),
        .inc_i   (idx_inc_s),
        .count_o (idx_s)
    );

    // Handshake and load-acceptance decode shared by both FSM processes.
    always_comb begin
        is_send_s  = (state_q == ST_SEND);
        is_last_s  = (idx_s == LAST_IDX);
        hs_s       = is_send_s && out_if.out_ready;
        ecc_ready  = !is_send_s || (hs_s && is_last_s);
        load_acc_s = ecc_load && ecc_ready;
    end

    // State, shift register and latched mask enable, async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            blank_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            blank_en_q <= blank_en_d;
        end
    end

    // Next state: flush beats load, load beats the plain handshake; a load
    // that lands on the last-word handshake restarts at word 0 seamlessly.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        blank_en_d = blank_en_q;
        idx_clr_s  = 1'b0;
        idx_inc_s  = 1'b0;
        if (flush) begin
            state_d   = ST_IDLE;
            shreg_d   = '0;
            idx_clr_s = 1'b1;
        end else if (load_acc_s) begin
            state_d    = ST_SEND;
            shreg_d    = SW'(ecc_in) << PAD;
            blank_en_d = blank_en;
            idx_clr_s  = 1'b1;
        end else if (hs_s) begin
            if (is_last_s) begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                idx_clr_s = 1'b1;
            end else begin
                shreg_d   = shreg_q << BITS;
                idx_inc_s = 1'b1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Outputs: word, qualifiers and mask-generator strobes; a flushed
    // cycle never advances the mask generator.
    always_comb begin
        mask_s           = blank_en_q ? blank_xor : '0;
        out_if.out_valid = is_send_s;
        out_if.out_first = is_send_s && (idx_s == '0);
        out_if.out_last  = is_send_s && is_last_s;
        blank_start      = is_send_s && (idx_s == '0);
        blank_ce         = hs_s && !is_last_s && !flush;
        if (is_send_s) begin
            out_if.out_data = shreg_q[SW-1 -: BITS] ^ mask_s;
        end else begin
            out_if.out_data = '0;
        end
    end

endmodule

// File: doc/bch_ecc_serializer.md
BCH_ECC_SERIALIZER -- requirements
Module: bch_ecc_serializer

Interface
REQ-001 Parameter P, default `BCH_SANE: BCH code parameter set; EB = `BCH_ECC_BITS(P).
REQ-002 Parameter BITS, default 1: output word width; ECC_WORDS = ceil(EB/BITS).
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port ecc_in  input  EB: parallel ECC remainder from the encoder.
REQ-006 Port ecc_load  input  1: request to load ecc_in.
REQ-007 Port ecc_ready  output  1: load accepted when ecc_load && ecc_ready.
REQ-008 Port blank_en  input  1: 1 = XOR the blank-flash mask, 0 = send raw ECC; sampled at load.
REQ-009 Port flush  input  1: synchronous abort of the current ECC burst.
REQ-010 Port blank_start  output  1: start strobe to the upstream blank-ECC mask generator.
REQ-011 Port blank_ce  output  1: advance strobe to the mask generator.
REQ-012 Port blank_xor  input  BITS: current mask word from the generator, combinational.
REQ-013 Port out_data  output  BITS: ECC word, MSB-first.
REQ-014 Port out_valid  output  1; out_ready  input  1: valid/ready output handshake.
REQ-015 Port out_first / out_last  output  1: qualify word 0 / word ECC_WORDS-1 while out_valid.

Function
REQ-016 States IDLE and SEND only.
REQ-017 IDLE: ecc_ready=1, out_valid=0, blank_start=0, blank_ce=0.
REQ-018 Load in IDLE: next cycle SEND, word index 0, shift register = ecc_in left-aligned in ECC_WORDS*BITS bits, pad LSBs zero; latency load->out_valid exactly 1 cycle.
REQ-019 SEND: out_valid=1; out_data = shreg top BITS XOR (blank_xor if latched blank_en else 0).
REQ-020 blank_start=1 exactly while word index 0 is presented, held through stalls.
REQ-021 blank_ce = out_valid && out_ready && word index < ECC_WORDS-1.
REQ-022 On a handshake: shift register left by BITS, index+1; out_data/out_first/out_last stable while out_valid && !out_ready.
REQ-023 out_first = (index==0); out_last = (index==ECC_WORDS-1); both asserted when ECC_WORDS==1.
REQ-024 Handshake on last word: return to IDLE unless a load occurs in the same cycle.
REQ-025 ecc_ready = IDLE || (out_valid && out_ready && out_last); a same-cycle load goes straight to SEND index 0 with no bubble.
REQ-026 ecc_load while ecc_ready=0: ignored, no state change.
REQ-027 flush: next state IDLE, index 0, no handshake that cycle is counted.
REQ-028 flush has priority over load and handshake when they occur in the same cycle.
REQ-029 Word index counts 0..ECC_WORDS-1 and never wraps past ECC_WORDS-1.

Reset
REQ-030 reset_n low asynchronously sets:
- state IDLE, index 0, shift register 0, latched blank_en 0;
- out_valid 0, blank_start 0, blank_ce 0, ecc_ready 1.
REQ-031 Deassertion of reset_n is synchronized externally; first load is legal on the first clock after deassertion.
REQ-032 Reset mid-burst discards the burst; no partial word is emitted afterwards.

Structure
REQ-033 EB, ECC_WORDS and index width ($clog2(ECC_WORDS+1)) SHALL derive from the shared `BCH_* macros in bch_defs.vh; no new literals.
REQ-034 The word index SHALL use the shared counter sub-module; no other sub-modules.

Verification
REQ-035 BITS=8, ECC_WORDS=13, ecc_in=0, blank_en=1, bench mask model returning 8'hFF, out_ready=1 -> 13 words of 8'hFF; out_first on word 0, out_last on word 12; blank_start 1 cycle; blank_ce 12 cycles.
REQ-036 blank_en=0, ecc_in=alternating 8'hA5/8'h3C words -> output equals ecc_in MSB-first; mask ignored.
REQ-037 out_ready toggled 1010... -> each word held stable while stalled; blank_start held through the word-0 stall; no blank_ce while stalled.
REQ-038 Load asserted in the cycle word 12 handshakes -> next burst word 0 in the following cycle; no idle gap.
REQ-039 flush at word 5 together with ecc_load -> IDLE next cycle; load ignored; ecc_ready=1.
REQ-040 EB=20, BITS=8 -> 3 words; word 2 low 4 bits = pad 0 XOR mask; reset_n pulsed at word 1 -> out_valid low immediately (asynchronous).
